// File: rtl/atom_arb_pkg.sv
// Shared types for the AtomRV fetch/data memory arbiter.
package atom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RESP_I = 2'd1,
      ST_RESP_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_own_t;

   localparam logic [2:0] WIDTH_WORD = 3'b010;

endpackage

// File: rtl/atom_arb_sel.sv
// Fetch/data priority pick: data wins unless fetch is alone or has been starved.
module atom_arb_sel
   import atom_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic starve_sat,
   output logic sel
);

   always_comb begin
      sel = OWN_D;
      if (i_req && (!d_req || starve_sat)) sel = OWN_I;
   end

endmodule

// File: rtl/atom_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between AtomRV fetch and data.
// state     | meaning
// ST_IDLE   | arbitrating; data writes complete here on grant
// ST_RESP_I | fetch read outstanding, waiting for m_rvalid_i or timeout
// ST_RESP_D | data read outstanding, waiting for m_rvalid_i or timeout
module atom_mem_arbiter
   import atom_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              i_req_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   output logic              i_gnt_o,
   output logic              i_rvalid_o,
   output logic [DATA_W-1:0] i_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [2:0]        d_width_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   output logic [2:0]        m_width_o,
   input  logic              m_gnt_i,
   input  logic              m_rvalid_i,
   input  logic [DATA_W-1:0] m_rdata_i,
   output logic              hlt_o,
   output logic              err_o
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam int TC_W = $clog2(TIMEOUT);
   localparam logic [SC_W-1:0] STARVE_SAT = SC_W'(STARVE_MAX);
   localparam logic [TC_W-1:0] TMO_LOAD   = TC_W'(TIMEOUT - 1);

   arb_state_t      state_q, state_d;
   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
   logic [TC_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            err_q, err_d;
   logic            sel;
   logic            resp_done;
   logic [DATA_W-1:0] resp_data;

   atom_arb_sel u_sel (
      .i_req      (i_req_i),
      .d_req      (d_req_i),
      .starve_sat (starve_cnt_q == STARVE_SAT),
      .sel        (sel)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= '0;
         tmo_cnt_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      err_d        = err_q;
      m_req_o      = 1'b0;
      m_we_o       = 1'b0;
      m_addr_o     = '0;
      m_wdata_o    = '0;
      m_width_o    = '0;
      i_gnt_o      = 1'b0;
      d_gnt_o      = 1'b0;
      i_rvalid_o   = 1'b0;
      d_rvalid_o   = 1'b0;
      i_rdata_o    = '0;
      d_rdata_o    = '0;
      // a genuine response in the terminal-count cycle wins over the timeout
      resp_done    = m_rvalid_i || (tmo_cnt_q == '0);
      resp_data    = m_rvalid_i ? m_rdata_i : '0;

      case (state_q)
         ST_IDLE: begin
            if (i_req_i || d_req_i) begin
               m_req_o = 1'b1;
               if (sel == OWN_I) begin
                  m_addr_o  = i_addr_i;
                  m_width_o = WIDTH_WORD;
                  i_gnt_o   = m_gnt_i;
                  if (m_gnt_i) begin
                     state_d   = ST_RESP_I;
                     tmo_cnt_d = TMO_LOAD;
                  end
               end else begin
                  m_we_o    = d_we_i;
                  m_addr_o  = d_addr_i;
                  m_wdata_o = d_wdata_i;
                  m_width_o = d_width_i;
                  d_gnt_o   = m_gnt_i;
                  if (m_gnt_i && !d_we_i) begin
                     state_d   = ST_RESP_D;
                     tmo_cnt_d = TMO_LOAD;
                  end
               end
            end
         end
         ST_RESP_I, ST_RESP_D: begin
            if (resp_done) begin
               i_rvalid_o = (state_q == ST_RESP_I);
               d_rvalid_o = (state_q == ST_RESP_D);
               i_rdata_o  = (state_q == ST_RESP_I) ? resp_data : '0;
               d_rdata_o  = (state_q == ST_RESP_D) ? resp_data : '0;
               state_d    = ST_IDLE;
               tmo_cnt_d  = '0;
               if (!m_rvalid_i) err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q - TC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!i_req_i || i_gnt_o) begin
         starve_cnt_d = '0;
      end else if (d_gnt_o && (starve_cnt_q != STARVE_SAT)) begin
         starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
   end

   assign hlt_o = (i_req_i && !i_rvalid_o) || (d_req_i && !(d_we_i ? d_gnt_o : d_rvalid_o));
   assign err_o = err_q;

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Directed bench for atom_mem_arbiter with STARVE_MAX=4, TIMEOUT=8.
module tb_atom_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        i_req_i, i_gnt_o, i_rvalid_o;
   logic [31:0] i_addr_i, i_rdata_o;
   logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
   logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
   logic [2:0]  d_width_i, m_width_o;
   logic        m_req_o, m_we_o, m_gnt_i, m_rvalid_i, hlt_o, err_o;
   logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;

   int n_chk = 0;
   int n_pass = 0;

   atom_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
      .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_width_i(d_width_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
      .m_width_o(m_width_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
      .hlt_o(hlt_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
   endtask

   task automatic idle_inputs();
      i_req_i = 0; i_addr_i = '0;
      d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_width_i = '0;
      m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
   endtask

   logic [1:0]  exp_win [6];
   logic [31:0] rd;

   initial begin
      idle_inputs();
      exp_win = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      // reset state and stray response
      @(negedge clk_i); #1;
      check("rst_ctl", {53'd0, m_req_o, m_we_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o,
                        hlt_o, err_o, m_width_o}, 64'd0);
      check("rst_data", {32'd0, m_addr_o | m_wdata_o | i_rdata_o | d_rdata_o}, 64'd0);
      @(negedge clk_i); m_rvalid_i = 1; m_rdata_i = 32'h1234_5678; #1;
      check("stray_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
      check("stray_rdata", {i_rdata_o, d_rdata_o}, 64'd0);

      // single fetch read
      @(negedge clk_i); idle_inputs(); i_req_i = 1; i_addr_i = 32'h100; m_gnt_i = 1; #1;
      check("f_mreq", {m_req_o, m_we_o, i_gnt_o, d_gnt_o, hlt_o, m_width_o}, {56'd0, 8'b1_0_1_0_1_010});
      check("f_addr", {32'd0, m_addr_o}, 64'h100);
      @(negedge clk_i); m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'hCAFE_F00D; #1;
      check("f_rv", {61'd0, m_req_o, i_rvalid_o, hlt_o}, 64'b010);
      check("f_rdata", {i_rdata_o, d_rdata_o}, {32'hCAFE_F00D, 32'd0});
      @(negedge clk_i); idle_inputs(); #1;
      check("f_rv_pulse", {62'd0, i_rvalid_o, hlt_o}, 64'd0);

      // starvation: four data wins, then fetch is forced through
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         i_req_i = 1; i_addr_i = 32'h400; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500;
         m_gnt_i = 1; m_rvalid_i = 0; #1;
         check($sformatf("arb%0d_gnt", k), {62'd0, i_gnt_o, d_gnt_o}, {62'd0, exp_win[k]});
         @(negedge clk_i); m_rvalid_i = 1; rd = 32'hD000_0000 + k; m_rdata_i = rd; #1;
         check($sformatf("arb%0d_rv", k), {62'd0, i_rvalid_o, d_rvalid_o}, {62'd0, exp_win[k]});
         check($sformatf("arb%0d_rdata", k), {i_rdata_o, d_rdata_o},
               exp_win[k][1] ? {rd, 32'd0} : {32'd0, rd});
      end
      @(negedge clk_i); idle_inputs();

      // back-to-back data writes
      @(negedge clk_i);
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h1111_1111; d_width_i = 3'b001;
      m_gnt_i = 0; #1;
      check("w_nognt", {61'd0, d_gnt_o, hlt_o, m_req_o}, 64'b011);
      @(negedge clk_i); m_gnt_i = 1; #1;
      check("w0_ctl", {59'd0, d_gnt_o, m_we_o, hlt_o, i_rvalid_o | d_rvalid_o, m_width_o == 3'b001},
            64'b11001);
      check("w0_bus", {m_addr_o, m_wdata_o}, {32'h200, 32'h1111_1111});
      @(negedge clk_i); d_addr_i = 32'h204; d_wdata_i = 32'h2222_2222; #1;
      check("w1_ctl", {61'd0, d_gnt_o, m_we_o, i_rvalid_o | d_rvalid_o}, 64'b110);
      check("w1_bus", {m_addr_o, m_wdata_o}, {32'h204, 32'h2222_2222});
      @(negedge clk_i); idle_inputs(); #1;
      check("w_done_rv", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);

      // data read timeout
      @(negedge clk_i); d_req_i = 1; d_addr_i = 32'h300; m_gnt_i = 1; #1;
      check("t_gnt", {63'd0, d_gnt_o}, 64'd1);
      for (int c = 1; c < 8; c++) begin
         @(negedge clk_i); m_gnt_i = 0; m_rdata_i = 32'hBAD0_BAD0; #1;
         check($sformatf("t_wait%0d", c), {61'd0, d_rvalid_o, hlt_o, err_o}, 64'b010);
      end
      @(negedge clk_i); #1;
      check("t_fire", {61'd0, d_rvalid_o, hlt_o, err_o}, 64'b100);
      check("t_rdata", {32'd0, d_rdata_o}, 64'd0);
      @(negedge clk_i); d_req_i = 0; i_req_i = 1; i_addr_i = 32'h80; m_gnt_i = 1; #1;
      check("t_idle_err", {62'd0, i_gnt_o, err_o}, 64'b11);
      @(negedge clk_i); m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h5A5A_5A5A; #1;
      check("t_sticky", {62'd0, i_rvalid_o, err_o}, 64'b11);

      // reset while a fetch is outstanding
      @(negedge clk_i); idle_inputs(); i_req_i = 1; i_addr_i = 32'h180; m_gnt_i = 1; #1;
      check("r_gnt", {63'd0, i_gnt_o}, 64'd1);
      @(negedge clk_i); rst_ni = 0; i_req_i = 0; m_gnt_i = 0; #1;
      check("r_in_rst", {61'd0, m_req_o, i_rvalid_o, err_o}, 64'd0);
      @(negedge clk_i); rst_ni = 1; m_rvalid_i = 1; m_rdata_i = 32'hDEAD_BEEF; #1;
      check("r_late_rv", {61'd0, i_rvalid_o, d_rvalid_o, err_o}, 64'd0);
      check("r_late_rdata", {i_rdata_o, d_rdata_o}, 64'd0);
      @(negedge clk_i); idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
